uart_tx_sched: RTL and testbench

Round-robin scheduler that shares one `uart_tx` transmitter between `p_NUM_REQ` requesters. It arbitrates among the requesters and hands one word at a time to the transmitter through a start/done handshake. A requester can keep the line for a burst of up to `p_MAX_BURST` words. A watchdog aborts the current owner if the transmitter never signals completion. The block sits between the protocol/host logic and the single UART TX serializer.

---
 rtl/uart_tx_sched.sv | 139 +++++++++++++
 tb/tb_uart_tx_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between p_NUM_REQ requesters,
// with per-grant burst cap and a completion watchdog.
module uart_tx_sched #(
  parameter int p_NUM_REQ   = 4,
  parameter int p_WORD_LEN  = 8,
  parameter int p_MAX_BURST = 16,
  parameter int p_TIMEOUT   = 4096
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [p_NUM_REQ-1:0]                 i_req,
  input  logic [p_NUM_REQ-1:0]                 i_last,
  input  logic [p_NUM_REQ*(p_WORD_LEN+1)-1:0]  i_data,
  output logic [p_NUM_REQ-1:0]                 o_ack,
  output logic [p_NUM_REQ-1:0]                 o_grant,
  output logic [p_WORD_LEN:0]                  o_tx_data,
  output logic                                 o_tx_start,
  input  logic                                 i_tx_done,
  output logic                                 o_busy,
  output logic                                 o_timeout
);

  localparam int W   = p_WORD_LEN + 1;
  localparam int PW  = $clog2(p_NUM_REQ);
  localparam int WDW = $clog2(p_TIMEOUT) + 1;
  localparam int BW  = $clog2(p_MAX_BURST) + 1;

  localparam logic [PW-1:0]        PTR_INIT   = PW'(p_NUM_REQ - 1);
  localparam logic [WDW-1:0]       WD_LIMIT   = WDW'(p_TIMEOUT - 1);
  localparam logic [BW-1:0]        BURST_MAX  = BW'(p_MAX_BURST);
  localparam logic [p_NUM_REQ-1:0] ONE        = {{(p_NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {s_IDLE, s_LAUNCH, s_WAIT} state_t;

  state_t         state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_owner;
  logic [BW-1:0]  r_burst;
  logic [WDW-1:0] r_wd;
  logic           r_last;

  logic [PW-1:0]  win_idx;
  logic [PW-1:0]  cand;
  logic           win_found;
  logic           owner_req;
  logic           owner_last;
  logic [W-1:0]   owner_word;
  logic           burst_go;

  // Winner is the first set request strictly after the last released owner.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 1; i <= p_NUM_REQ; i++) begin
      cand = PW'((int'(r_ptr) + i) % p_NUM_REQ);
      if (!win_found && i_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_word = '0;
    for (int k = 0; k < p_NUM_REQ; k++) begin
      if (r_owner == PW'(k)) owner_word = i_data[k*W +: W];
    end
  end

  assign owner_req  = i_req[r_owner];
  assign owner_last = i_last[r_owner];
  assign burst_go   = !r_last && owner_req && (r_burst < BURST_MAX);
  assign o_busy     = (state != s_IDLE);

  // Handshake: a word is consumed (o_ack) exactly when it is launched (o_tx_start);
  // the transmitter answers each launch with one i_tx_done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= s_IDLE;
      r_ptr      <= PTR_INIT;
      r_owner    <= '0;
      r_burst    <= '0;
      r_wd       <= '0;
      r_last     <= 1'b0;
      o_grant    <= '0;
      o_ack      <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_ack      <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        s_IDLE: begin
          if (win_found) begin
            o_grant <= ONE << win_idx;
            r_owner <= win_idx;
            state   <= s_LAUNCH;
          end
        end
        s_LAUNCH: begin
          if (owner_req) begin
            o_tx_data  <= owner_word;
            o_tx_start <= 1'b1;
            o_ack      <= ONE << r_owner;
            r_last     <= owner_last;
            r_burst    <= r_burst + 1'b1;
            r_wd       <= '0;
            state      <= s_WAIT;
          end else begin
            o_grant <= '0;
            r_burst <= '0;
            state   <= s_IDLE;
          end
        end
        s_WAIT: begin
          // The timeout pulse is shown with the culprit still granted; release follows.
          if (o_timeout || (i_tx_done && !burst_go)) begin
            o_grant <= '0;
            r_ptr   <= r_owner;
            r_burst <= '0;
            r_wd    <= '0;
            state   <= s_IDLE;
          end else if (i_tx_done) begin
            state <= s_LAUNCH;
          end else if (r_wd == WD_LIMIT) begin
            o_timeout <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: state <= s_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester/transmitter drivers, a transaction-level
// reference model checked every cycle, and directed literal checks.
module tb_uart_tx_sched;
  localparam int N  = 4;
  localparam int WL = 8;
  localparam int W  = WL + 1;
  localparam int MB = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, last;
  logic [N*W-1:0] data;
  logic           tx_done;
  logic [N-1:0]   ack, grant;
  logic [W-1:0]   tx_data;
  logic           tx_start, busy, timeout;

  uart_tx_sched #(.p_NUM_REQ(N), .p_WORD_LEN(WL), .p_MAX_BURST(MB), .p_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_last(last), .i_data(data),
    .o_ack(ack), .o_grant(grant), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_tx_done(tx_done), .o_busy(busy), .o_timeout(timeout)
  );

  // driver state
  int           words_left[N];
  logic [N-1:0] all_last, block;
  logic [W-1:0] base[N];
  int           done_delay, done_at, cyc;
  bit           force_done;
  logic [N-1:0] ack_s;

  // logs and scoreboard
  int           start_log[$];
  int           start_cyc_log[$];
  logic [N-1:0] start_grant_log[$];
  int           tout_cyc[$];
  logic [N-1:0] tout_grant[$];
  logic [W-1:0] exp_q[$];
  int           tests, fails;

  // reference model: owner index (-1 = none), launch pending, words in grant,
  // wait cycles since launch, timeout reported
  int           m_owner, m_words, m_waited, m_ptr;
  bit           m_launch, m_last, m_tout, model_valid;
  logic [N-1:0] e_grant, e_ack;
  logic [W-1:0] e_data;
  logic         e_start, e_timeout, e_busy;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    idx_of = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx_of = i;
  endfunction

  task automatic model_release();
    m_ptr    = m_owner;
    m_owner  = -1;
    m_words  = 0;
    m_tout   = 0;
  endtask

  task automatic model_step();
    e_start   = 1'b0;
    e_ack     = '0;
    e_timeout = 1'b0;
    if (rst) begin
      m_owner = -1; m_launch = 0; m_words = 0; m_waited = 0;
      m_ptr = N - 1; m_tout = 0; m_last = 0; e_data = '0;
    end else if (m_owner < 0) begin
      if (req != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        end
        m_launch = 1;
      end
    end else if (m_launch) begin
      m_launch = 0;
      if (req[m_owner]) begin
        e_data   = data[m_owner*W +: W];
        e_start  = 1'b1;
        e_ack[m_owner] = 1'b1;
        m_last   = last[m_owner];
        m_words++;
        m_waited = 0;
      end else begin
        m_owner = -1;
        m_words = 0;
      end
    end else begin
      m_waited++;
      if (m_tout) model_release();
      else if (tx_done) begin
        if (!m_last && req[m_owner] && m_words < MB) m_launch = 1;
        else model_release();
      end else if (m_waited == TO) begin
        e_timeout = 1'b1;
        m_tout    = 1;
      end
    end
    e_grant = (m_owner >= 0) ? ({{(N-1){1'b0}}, 1'b1} << m_owner) : '0;
    e_busy  = (m_owner >= 0);
  endtask

  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      req[k]  = (words_left[k] > 0) && !block[k];
      last[k] = all_last[k] || (words_left[k] == 1);
      data[k*W +: W] = base[k] + W'(words_left[k]) - W'(1);
    end
    tx_done = force_done || (done_at >= 0 && cyc == done_at);
  endtask

  // One clock: compare at negedge, model at posedge, drive inputs 1ns later.
  task automatic tick();
    @(negedge clk);
    if (model_valid) begin
      check("grant", grant, e_grant);
      check("ack", ack, e_ack);
      check("tx_start", tx_start, e_start);
      check("tx_data", tx_data, e_data);
      check("busy", busy, e_busy);
      check("timeout", timeout, e_timeout);
    end
    ack_s = ack;
    if (tx_start) begin
      start_log.push_back(idx_of(grant));
      start_cyc_log.push_back(cyc);
      start_grant_log.push_back(grant);
      if (done_delay > 0) done_at = cyc + done_delay;
    end
    if (timeout) begin
      tout_cyc.push_back(cyc);
      tout_grant.push_back(grant);
    end
    @(posedge clk);
    model_step();
    if (rst) model_valid = 1;
    cyc++;
    #1;
    for (int k = 0; k < N; k++) if (ack_s[k] && words_left[k] > 0) words_left[k]--;
    apply_inputs();
    force_done = 0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int b;
    b = 0;
    while (start_log.size() < n && b < budget) begin tick(); b++; end
    check(name, start_log.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int b;
    b = 0;
    while (busy && b < budget) begin tick(); b++; end
    check(name, busy, 1'b0);
  endtask

  task automatic check_seq(input string name, input int first);
    int i;
    logic [W-1:0] e;
    i = first;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (i < start_log.size()) check(name, start_log[i], e);
      else check(name, 32'hFFFF_FFFF, e);
      i++;
    end
  endtask

  initial begin
    int c0, s;
    tests = 0; fails = 0; cyc = 0; model_valid = 0;
    rst = 1'b1; all_last = '1; block = '0;
    done_delay = 5; done_at = -1; force_done = 0;
    base[0] = 9'h0A5; base[1] = 9'h111; base[2] = 9'h122; base[3] = 9'h133;
    for (int k = 0; k < N; k++) words_left[k] = 0;
    apply_inputs();
    repeat (3) tick();
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_start", tx_start, 1'b0);
    check("rst_ack", ack, 4'b0000);
    check("rst_data", tx_data, 9'h000);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0;
    tick();

    // round robin: two single-word bursts each, from reset pointer
    for (int k = 0; k < N; k++) words_left[k] = 2;
    apply_inputs();
    wait_starts(8, 200, "rr_count");
    wait_idle(50, "rr_idle");
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(i % 4));
    check_seq("rr_order", 0);
    start_log.delete(); start_cyc_log.delete(); start_grant_log.delete();

    // single request, latency and data
    words_left[0] = 1;
    apply_inputs();
    c0 = cyc;
    wait_starts(1, 20, "single_count");
    check("single_latency", start_cyc_log[0] - c0, 2);
    check("single_grant", start_grant_log[0], 4'b0001);
    check("single_data", tx_data, 9'h0A5);
    while (cyc < start_cyc_log[0] + 6) tick();
    check("single_rel_grant", grant, 4'b0000);
    check("single_rel_busy", busy, 1'b0);
    start_log.delete(); start_cyc_log.delete(); start_grant_log.delete();

    // withdraw: requester 1 drops request while in launch
    words_left[1] = 1;
    apply_inputs();
    block[1] = 1'b1;
    tick();
    check("wd_grant", grant, 4'b0010);
    tick();
    check("wd_cleared", grant, 4'b0000);
    repeat (3) tick();
    check("wd_no_start", start_log.size(), 0);
    block[1] = 1'b0;
    words_left[3] = 1;
    apply_inputs();
    wait_starts(2, 40, "wd_count");
    wait_idle(50, "wd_idle");
    exp_q.push_back(9'd1); exp_q.push_back(9'd3);
    check_seq("wd_order", 0);
    start_log.delete(); start_cyc_log.delete(); start_grant_log.delete();

    // burst cap of 3 words
    all_last[2] = 1'b0;
    words_left[2] = 5;
    words_left[3] = 1;
    apply_inputs();
    wait_starts(6, 300, "burst_count");
    wait_idle(50, "burst_idle");
    exp_q.push_back(9'd2); exp_q.push_back(9'd2); exp_q.push_back(9'd2);
    exp_q.push_back(9'd3); exp_q.push_back(9'd2); exp_q.push_back(9'd2);
    check_seq("burst_order", 0);
    all_last[2] = 1'b1;
    start_log.delete(); start_cyc_log.delete(); start_grant_log.delete();

    // watchdog: transmitter never answers
    done_delay = 0;
    words_left[0] = 1;
    apply_inputs();
    wait_starts(1, 20, "tout_start");
    s = start_cyc_log[0];
    c0 = 0;
    while (tout_cyc.size() < 1 && c0 < 20) begin tick(); c0++; end
    check("tout_seen", tout_cyc.size(), 1);
    if (tout_cyc.size() > 0) begin
      check("tout_delay", tout_cyc[0] - s, 8);
      check("tout_culprit", tout_grant[0], 4'b0001);
    end
    check("tout_idle", busy, 1'b0);
    force_done = 1;
    repeat (3) tick();
    check("late_done_start", start_log.size(), 1);
    check("late_done_tout", tout_cyc.size(), 1);
    start_log.delete(); start_cyc_log.delete(); start_grant_log.delete();

    // reset in the middle of a wait
    words_left[1] = 1;
    apply_inputs();
    wait_starts(1, 20, "mid_start");
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_grant", grant, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_data", tx_data, 9'h000);
    check("mid_rst_ack", ack, 4'b0000);
    force_done = 1;
    repeat (2) tick();
    check("mid_rst_no_start", start_log.size(), 1);
    done_delay = 5;
    words_left[0] = 1;
    words_left[2] = 1;
    apply_inputs();
    wait_starts(3, 60, "mid_rst_count");
    wait_idle(50, "mid_rst_idle");
    exp_q.push_back(9'd0); exp_q.push_back(9'd2);
    check_seq("mid_rst_order", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
